// File: rtl/lcd12864_bus_receiver.sv
// ST7920-style LCD12864 parallel bus responder with a 64-byte DDRAM image.
// Optional bus readback (busy/address and data reads) under LCDRX_READBACK_EN.
module lcd12864_bus_receiver #(
    parameter int unsigned BUSY_CYCLES = 8,
    parameter logic [7:0]  CLR_CHAR    = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_dat,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       disp_on,
    output logic       cur_on,
    output logic       blink_on,
    output logic [5:0] cursor,
    output logic       wr_stb,
    output logic       ovr_err,
    output logic       unk_cmd,
    output logic [7:0] dat_o,
    output logic       dat_oe
);
    localparam int CW = $clog2(BUSY_CYCLES + 2);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;
    state_t state, state_nx;

    logic          rs_s1, rs_s2, rw_s1, rw_s2, en_s1, en_s2;
    logic [7:0]    dat_s1, dat_s2;
    logic          cap_rs, cap_rw;
    logic [7:0]    cap_dat;
    logic [CW-1:0] busy_cnt;
    logic [5:0]    clr_cnt;
    logic          inc, ext;
    logic [7:0]    mem [0:63];

    logic en_fall, xfer, accept, ovr;
    logic do_clear, do_home, do_entry, do_disp, do_func, do_addr;
    logic do_wr, do_rd, do_unk;
    logic          we;
    logic [5:0]    waddr;
    logic [7:0]    wdata;

    assign en_fall = en_s2 & ~en_s1;
`ifdef LCDRX_READBACK_EN
    // Busy/address reads are free polling; only data reads move the cursor.
    assign xfer = en_fall & (~rw_s2 | rs_s2);
`else
    assign xfer = en_fall & ~rw_s2;
`endif
    assign busy   = (state != S_IDLE) | (busy_cnt != '0);
    assign accept = xfer & ~busy;
    assign ovr    = xfer & busy;

    always_comb begin
        do_clear = 1'b0;
        do_home  = 1'b0;
        do_entry = 1'b0;
        do_disp  = 1'b0;
        do_func  = 1'b0;
        do_addr  = 1'b0;
        do_wr    = 1'b0;
        do_rd    = 1'b0;
        do_unk   = 1'b0;
        if (state == S_EXEC) begin
            if (cap_rs) begin
                do_wr = ~cap_rw;
                do_rd = cap_rw;
            end else if (!cap_rw) begin
                if (cap_dat[7:5] == 3'b001) begin
                    do_func = 1'b1;
                end else if (ext) begin
                    do_unk = 1'b1;
                end else begin
                    casez (cap_dat)
                        8'h01:       do_clear = 1'b1;
                        8'b0000_001?: do_home  = 1'b1;
                        8'b0000_01??: do_entry = 1'b1;
                        8'b0000_1???: do_disp  = 1'b1;
                        8'b100?_????: do_addr  = 1'b1;
                        default:     do_unk   = 1'b1;
                    endcase
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (accept) state_nx = S_EXEC;
            S_EXEC:  state_nx = do_clear ? S_CLEAR : S_IDLE;
            S_CLEAR: if (clr_cnt == 6'd63) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rs_s1, rs_s2, rw_s1, rw_s2, en_s1, en_s2} <= '0;
            dat_s1   <= '0;
            dat_s2   <= '0;
            state    <= S_CLEAR;
            cap_rs   <= 1'b0;
            cap_rw   <= 1'b0;
            cap_dat  <= '0;
            busy_cnt <= '0;
            clr_cnt  <= '0;
            inc      <= 1'b1;
            ext      <= 1'b0;
            cursor   <= '0;
            disp_on  <= 1'b0;
            cur_on   <= 1'b0;
            blink_on <= 1'b0;
            ovr_err  <= 1'b0;
        end else begin
            rs_s1  <= lcd_rs;
            rs_s2  <= rs_s1;
            rw_s1  <= lcd_rw;
            rw_s2  <= rw_s1;
            en_s1  <= lcd_en;
            en_s2  <= en_s1;
            dat_s1 <= lcd_dat;
            dat_s2 <= dat_s1;
            state  <= state_nx;
            if (accept) begin
                cap_rs  <= rs_s2;
                cap_rw  <= rw_s2;
                cap_dat <= dat_s2;
            end
            if (ovr) ovr_err <= 1'b1;
            if (state == S_EXEC) busy_cnt <= CW'(BUSY_CYCLES);
            else if (busy_cnt != '0) busy_cnt <= busy_cnt - CW'(1);
            if (state == S_CLEAR) begin
                if (clr_cnt == 6'd63) begin
                    clr_cnt <= '0;
                    cursor  <= '0;
                    inc     <= 1'b1;
                end else begin
                    clr_cnt <= clr_cnt + 6'd1;
                end
            end
            if (do_home)  cursor <= '0;
            if (do_entry) inc    <= cap_dat[1];
            if (do_disp) begin
                disp_on  <= cap_dat[2];
                cur_on   <= cap_dat[1];
                blink_on <= cap_dat[0];
            end
            if (do_func) ext    <= cap_dat[2];
            if (do_addr) cursor <= {cap_dat[4:0], 1'b0};
            if (do_wr || do_rd) cursor <= inc ? cursor + 6'd1 : cursor - 6'd1;
        end
    end

    assign we    = (state == S_CLEAR) | do_wr;
    assign waddr = (state == S_CLEAR) ? clr_cnt : cursor;
    assign wdata = (state == S_CLEAR) ? CLR_CHAR : cap_dat;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

    assign wr_stb  = do_wr;
    assign unk_cmd = do_unk;

`ifdef LCDRX_READBACK_EN
    always_comb begin
        dat_o  = '0;
        dat_oe = 1'b0;
        if (en_s2 && rw_s2) begin
            dat_oe = 1'b1;
            dat_o  = rs_s2 ? mem[cursor] : {busy, 2'b00, cursor[5:1]};
        end
    end
`else
    assign dat_o  = '0;
    assign dat_oe = 1'b0;
`endif
endmodule

// File: tb/tb_lcd12864_bus_receiver.sv
// Scoreboard bench for lcd12864_bus_receiver: directed bus transfers,
// queued expectations for wr_stb/unk_cmd pulses, readback of the DDRAM image.
module tb_lcd12864_bus_receiver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] lcd_dat = '0;
    logic [5:0] rd_addr = '0;
    logic [7:0] rd_data, dat_o;
    logic       busy, disp_on, cur_on, blink_on, wr_stb, ovr_err, unk_cmd, dat_oe;
    logic [5:0] cursor;

    int n_chk = 0;
    int n_fail = 0;
    logic [5:0] wr_q[$];
    logic [8:0] unk_q[$];

    lcd12864_bus_receiver dut (
        .clk(clk), .rst_n(rst_n),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .disp_on(disp_on), .cur_on(cur_on), .blink_on(blink_on),
        .cursor(cursor), .wr_stb(wr_stb), .ovr_err(ovr_err),
        .unk_cmd(unk_cmd), .dat_o(dat_o), .dat_oe(dat_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation for every pulse the DUT presents.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_stb) begin
                if (wr_q.size() == 0) chk("wr_stb_unexpected", 32'd1, 32'd0);
                else chk("wr_addr", {26'd0, cursor}, {26'd0, wr_q.pop_front()});
            end
            if (unk_cmd) begin
                if (unk_q.size() == 0) chk("unk_cmd_unexpected", 32'd1, 32'd0);
                else chk("unk_state", {23'd0, disp_on, cur_on, blink_on, cursor},
                         {23'd0, unk_q.pop_front()});
            end
        end
    end

    task automatic wait_ready();
        int i = 0;
        while (busy && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL busy_timeout: busy still %0b after %0d clks", busy, i);
        end
    endtask

    task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d,
                            input bit wait_rdy = 1'b1);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_dat = d;
        @(negedge clk);
        lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
        repeat (3) @(negedge clk);
        lcd_rw = 1'b0;
        if (wait_rdy) wait_ready();
    endtask

    task automatic rd_chk(input logic [5:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk($sformatf("ddram[%0d]", a), {24'd0, rd_data}, {24'd0, exp});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_flags", {28'd0, disp_on, cur_on, blink_on, ovr_err}, 32'd0);
        chk("rst_cursor", {26'd0, cursor}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("rst_oe", {31'd0, dat_oe}, 32'd0);
        rst_n = 1'b1;

        // Power-up fill
        repeat (70) @(negedge clk);
        chk("fill_busy", {31'd0, busy}, 32'd0);
        rd_chk(6'd0, 8'h20);
        rd_chk(6'd31, 8'h20);
        rd_chk(6'd63, 8'h20);
        chk("fill_cursor", {26'd0, cursor}, 32'd0);

        // Init sequence and "Lyc"
        bus_xfer(1'b0, 1'b0, 8'h30);
        bus_xfer(1'b0, 1'b0, 8'h0C);
        bus_xfer(1'b0, 1'b0, 8'h06);
        bus_xfer(1'b0, 1'b0, 8'h01);
        wr_q.push_back(6'd0); bus_xfer(1'b1, 1'b0, 8'h4C);
        wr_q.push_back(6'd1); bus_xfer(1'b1, 1'b0, 8'h79);
        wr_q.push_back(6'd2); bus_xfer(1'b1, 1'b0, 8'h63);
        chk("disp_on", {31'd0, disp_on}, 32'd1);
        chk("cur_on", {31'd0, cur_on}, 32'd0);
        chk("cursor_after_lyc", {26'd0, cursor}, 32'd3);
        rd_chk(6'd0, 8'h4C);
        rd_chk(6'd1, 8'h79);
        rd_chk(6'd2, 8'h63);

        // Row 1 and wrap at the top of DDRAM
        bus_xfer(1'b0, 1'b0, 8'h90);
        wr_q.push_back(6'd32); bus_xfer(1'b1, 1'b0, 8'h4E);
        wr_q.push_back(6'd33); bus_xfer(1'b1, 1'b0, 8'h49);
        bus_xfer(1'b0, 1'b0, 8'h9F);
        wr_q.push_back(6'd62); bus_xfer(1'b1, 1'b0, 8'h41);
        wr_q.push_back(6'd63); bus_xfer(1'b1, 1'b0, 8'h42);
        chk("cursor_wrap_up", {26'd0, cursor}, 32'd0);
        rd_chk(6'd32, 8'h4E);
        rd_chk(6'd33, 8'h49);
        rd_chk(6'd62, 8'h41);
        rd_chk(6'd63, 8'h42);

        // Decrement mode wraps downward
        bus_xfer(1'b0, 1'b0, 8'h04);
        bus_xfer(1'b0, 1'b0, 8'h80);
        wr_q.push_back(6'd0); bus_xfer(1'b1, 1'b0, 8'h58);
        chk("cursor_wrap_down", {26'd0, cursor}, 32'd63);
        rd_chk(6'd0, 8'h58);

        // Extended instruction set ignores basic commands
        bus_xfer(1'b0, 1'b0, 8'h34);
        unk_q.push_back({3'b100, 6'd63}); bus_xfer(1'b0, 1'b0, 8'h0C);
        chk("disp_on_ext", {29'd0, disp_on, cur_on, blink_on}, 32'b100);
        bus_xfer(1'b0, 1'b0, 8'h30);
        unk_q.push_back({3'b100, 6'd63}); bus_xfer(1'b0, 1'b0, 8'h40);

        // Overrun: second data write lands 3 clks after the first
        bus_xfer(1'b0, 1'b0, 8'h06);
        bus_xfer(1'b0, 1'b0, 8'h88);
        wr_q.push_back(6'd16);
        @(negedge clk);
        lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_dat = 8'h11; lcd_en = 1'b1;
        repeat (2) @(negedge clk);
        lcd_en = 1'b0;
        @(negedge clk);
        lcd_dat = 8'h22; lcd_en = 1'b1;
        repeat (2) @(negedge clk);
        lcd_en = 1'b0;
        repeat (3) @(negedge clk);
        wait_ready();
        chk("ovr_err", {31'd0, ovr_err}, 32'd1);
        chk("cursor_after_ovr", {26'd0, cursor}, 32'd17);
        rd_chk(6'd16, 8'h11);
        rd_chk(6'd17, 8'h20);
        bus_xfer(1'b0, 1'b0, 8'h0F);
        chk("ovr_sticky", {31'd0, ovr_err}, 32'd1);
        chk("blink_on", {29'd0, disp_on, cur_on, blink_on}, 32'b111);

        // Reset in the middle of a clear
        bus_xfer(1'b0, 1'b0, 8'h01, 1'b0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midclr_rst_busy", {31'd0, busy}, 32'd1);
        chk("midclr_rst_ovr", {31'd0, ovr_err}, 32'd0);
        chk("midclr_rst_flags", {29'd0, disp_on, cur_on, blink_on}, 32'd0);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        chk("refill_busy", {31'd0, busy}, 32'd0);
        for (int a = 0; a < 64; a++) rd_chk(6'(a), 8'h20);

        // Bus readback of busy flag / address counter
        bus_xfer(1'b0, 1'b0, 8'h88);
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
`ifdef LCDRX_READBACK_EN
        chk("rb_oe", {31'd0, dat_oe}, 32'd1);
        chk("rb_dat", {24'd0, dat_o}, 32'h08);
`else
        chk("rb_oe", {31'd0, dat_oe}, 32'd0);
        chk("rb_dat", {24'd0, dat_o}, 32'h00);
`endif
        lcd_en = 1'b0;
        repeat (4) @(negedge clk);
        lcd_rw = 1'b0;
        chk("rb_oe_after", {31'd0, dat_oe}, 32'd0);
        chk("rb_no_ovr", {31'd0, ovr_err}, 32'd0);
        chk("rb_cursor", {26'd0, cursor}, 32'd16);

        repeat (5) @(negedge clk);
        chk("wr_q_drained", wr_q.size(), 32'd0);
        chk("unk_q_drained", unk_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
